// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle MIPS core: owns the PC, fetches over req/ack, computes next PC.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_TMO = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        err_tmo,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_retired,
  output logic [31:0] perf_wait,
`endif
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req stays high from the first S_REQ cycle until the cycle
  // imem_ack is sampled high; imem_rdata is captured on that same rising edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(IMEM_TMO);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] br_off;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      tmo_cnt_q <= 8'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign pc_plus4_w = pc_q + 32'd4;
  assign br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc_raw = pc_plus4_w;
    if (jump) begin
      next_pc_raw = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc_raw = pc_plus4_w + br_off;
    end
    next_pc = next_pc_raw & 32'hFFFF_FFFC;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          instr_d   = imem_rdata;
          tmo_cnt_d = 8'h0;
          state_d   = S_EXEC;
        end else begin
          // Counter parks at the limit; the error flag is sticky anyway.
          if (tmo_cnt_q != TMO_LIM) tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_q == TMO_LIM - 8'd1) err_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= 32'h0;
      perf_wait_q    <= 32'h0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_wait_q    <= perf_wait_d;
    end
  end

  always_comb begin
    perf_retired_d = perf_retired_q;
    perf_wait_d    = perf_wait_q;
    if (state_q == S_EXEC && !stall && perf_retired_q != 32'hFFFF_FFFF)
      perf_retired_d = perf_retired_q + 32'd1;
    if (state_q == S_REQ && !imem_ack && perf_wait_q != 32'hFFFF_FFFF)
      perf_wait_d = perf_wait_q + 32'd1;
  end

  assign perf_retired = perf_retired_q;
  assign perf_wait    = perf_wait_q;
`endif

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_EXEC);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign err_tmo     = err_q;
  assign dbg_state   = state_q;

endmodule
